// File: rtl/wb_uart_pkg.sv
// Shared definitions for wb_uart: register offsets, STAT bit positions, FSM encodings.
package wb_uart_pkg;

    localparam logic [2:0] REG_TXDATA = 3'd0;
    localparam logic [2:0] REG_RXDATA = 3'd1;
    localparam logic [2:0] REG_STAT   = 3'd2;
    localparam logic [2:0] REG_DIV    = 3'd3;
    localparam logic [2:0] REG_IEN    = 3'd4;

    localparam int STAT_RX_VALID  = 0;
    localparam int STAT_TX_FULL   = 1;
    localparam int STAT_TX_EMPTY  = 2;
    localparam int STAT_TX_BUSY   = 3;
    localparam int STAT_RXOVR     = 4;
    localparam int STAT_FRAME_ERR = 5;
    localparam int STAT_TXOVF     = 6;

    localparam logic [15:0] DIV_RST_DEF = 16'd434;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    // A divisor below 2 would leave no room for the mid-bit RX sample.
    function automatic logic [15:0] clamp_div(input logic [15:0] d);
        return (d < 16'd2) ? 16'd2 : d;
    endfunction

endpackage

// File: rtl/wb_uart_fifo.sv
// Synchronous FIFO with wrap-bit pointers; head is visible combinationally on pop_dat.
// Push when full and pop when empty are ignored; push and pop together are both honoured.
module wb_uart_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_dat,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop_dat = mem[rd_ptr[AW-1:0]];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_dat;
    end

endmodule

// File: rtl/wb_uart.sv
// Wishbone classic slave 8N1 UART: TX FIFO + shifter, RX with one-byte holding register.
// Registered ack one cycle after each access (never stalls); a full TX FIFO drops the byte and flags txovf.
module wb_uart
    import wb_uart_pkg::*;
#(
    parameter int          WB_AD_WIDTH  = 32,
    parameter int          WB_DAT_WIDTH = 32,
    parameter int          TX_DEPTH     = 8,
    parameter logic [15:0] DIV_RST      = DIV_RST_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      wbs_cyc_i,
    input  logic                      wbs_stb_i,
    input  logic                      wbs_we_i,
    input  logic [WB_AD_WIDTH-1:0]    wbs_addr_i,
    input  logic [WB_DAT_WIDTH-1:0]   wbs_wdata_i,
    input  logic [WB_DAT_WIDTH/8-1:0] wbs_sel_i,
    output logic [WB_DAT_WIDTH-1:0]   wbs_rdata_o,
    output logic                      wbs_ack_o,
    input  logic                      uart_rx_i,
    output logic                      uart_tx_o,
    output logic                      irq_o
);

    logic                    ack_q;
    logic [WB_DAT_WIDTH-1:0] rdata_q;
    logic [WB_DAT_WIDTH-1:0] rd_val;
    logic [2:0]              reg_idx;
    logic                    access, wr, rd;
    logic                    tx_push_req, rd_rx, stat_wr, div_wr, ien_wr;
    logic [15:0]             div, new_div;
    logic [1:0]              ien;
    logic                    irq_q;
    logic                    rx_valid, rxovr, frame_err, txovf;
    logic [7:0]              rx_byte;
    logic [6:0]              stat_val;
    logic                    unused_bits;

    logic                    fifo_full, fifo_empty, tx_pop;
    logic [7:0]              fifo_head;
    logic [1:0]              tx_state;
    logic [15:0]             tx_cnt;
    logic [2:0]              tx_bit;
    logic [7:0]              tx_sh;
    logic                    tx_line, tx_end, tx_busy;

    logic [1:0]              rx_sync;
    logic                    rx_s, rx_prev;
    logic [1:0]              rx_state;
    logic [15:0]             rx_cnt;
    logic [2:0]              rx_bit;
    logic [7:0]              rx_sh;
    logic                    rx_end, rx_mid, rx_stop_done;

    assign unused_bits = ^{wbs_addr_i[WB_AD_WIDTH-1:5], wbs_addr_i[1:0],
                           wbs_wdata_i[WB_DAT_WIDTH-1:16], wbs_sel_i[WB_DAT_WIDTH/8-1:2]};

    assign access  = wbs_cyc_i && wbs_stb_i && !ack_q;
    assign wr      = access && wbs_we_i;
    assign rd      = access && !wbs_we_i;
    assign reg_idx = wbs_addr_i[4:2];

    assign tx_push_req = wr && (reg_idx == REG_TXDATA) && wbs_sel_i[0];
    assign rd_rx       = rd && (reg_idx == REG_RXDATA);
    assign stat_wr     = wr && (reg_idx == REG_STAT) && wbs_sel_i[0];
    assign div_wr      = wr && (reg_idx == REG_DIV) && (|wbs_sel_i[1:0]);
    assign ien_wr      = wr && (reg_idx == REG_IEN) && wbs_sel_i[0];
    assign new_div     = {wbs_sel_i[1] ? wbs_wdata_i[15:8] : div[15:8],
                          wbs_sel_i[0] ? wbs_wdata_i[7:0]  : div[7:0]};

    assign tx_busy = !fifo_empty || (tx_state != ST_IDLE);

    always_comb begin
        stat_val                 = '0;
        stat_val[STAT_RX_VALID]  = rx_valid;
        stat_val[STAT_TX_FULL]   = fifo_full;
        stat_val[STAT_TX_EMPTY]  = fifo_empty;
        stat_val[STAT_TX_BUSY]   = tx_busy;
        stat_val[STAT_RXOVR]     = rxovr;
        stat_val[STAT_FRAME_ERR] = frame_err;
        stat_val[STAT_TXOVF]     = txovf;
    end

    always_comb begin
        rd_val = '0;
        case (reg_idx)
            REG_RXDATA: begin
                rd_val[31]  = rx_valid;
                rd_val[7:0] = rx_byte;
            end
            REG_STAT: rd_val[6:0]  = stat_val;
            REG_DIV:  rd_val[15:0] = div;
            REG_IEN:  rd_val[1:0]  = ien;
            default:  rd_val       = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            ack_q   <= 1'b0;
            rdata_q <= '0;
            irq_q   <= 1'b0;
        end else begin
            ack_q   <= access;
            rdata_q <= rd ? rd_val : '0;
            irq_q   <= (ien[0] && rx_valid) || (ien[1] && fifo_empty && !tx_busy);
        end
    end

    // ---------------- TX ----------------
    wb_uart_fifo #(.DEPTH(TX_DEPTH), .WIDTH(8)) u_tx_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (tx_push_req),
        .push_dat (wbs_wdata_i[7:0]),
        .pop      (tx_pop),
        .pop_dat  (fifo_head),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    // Comparing with >= lets a DIV shrink mid-bit end that bit instead of wrapping.
    assign tx_end = (tx_cnt >= div - 16'd1);
    assign tx_pop = !fifo_empty && ((tx_state == ST_IDLE) || ((tx_state == ST_STOP) && tx_end));

    always_ff @(posedge clk) begin
        if (!rst) begin
            tx_state <= ST_IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_sh    <= '0;
            tx_line  <= 1'b1;
        end else begin
            case (tx_state)
                ST_IDLE: begin
                    tx_line <= 1'b1;
                    tx_cnt  <= '0;
                    if (tx_pop) begin
                        tx_sh    <= fifo_head;
                        tx_state <= ST_START;
                        tx_line  <= 1'b0;
                    end
                end
                ST_START: begin
                    if (tx_end) begin
                        tx_cnt   <= '0;
                        tx_bit   <= '0;
                        tx_state <= ST_DATA;
                        tx_line  <= tx_sh[0];
                    end else begin
                        tx_cnt <= tx_cnt + 16'd1;
                    end
                end
                ST_DATA: begin
                    if (tx_end) begin
                        tx_cnt <= '0;
                        if (tx_bit == 3'd7) begin
                            tx_state <= ST_STOP;
                            tx_line  <= 1'b1;
                        end else begin
                            tx_bit  <= tx_bit + 3'd1;
                            tx_sh   <= {1'b0, tx_sh[7:1]};
                            tx_line <= tx_sh[1];
                        end
                    end else begin
                        tx_cnt <= tx_cnt + 16'd1;
                    end
                end
                default: begin
                    if (tx_end) begin
                        tx_cnt <= '0;
                        // Chain straight into the next start bit so queued frames have no gap.
                        if (tx_pop) begin
                            tx_sh    <= fifo_head;
                            tx_state <= ST_START;
                            tx_line  <= 1'b0;
                        end else begin
                            tx_state <= ST_IDLE;
                        end
                    end else begin
                        tx_cnt <= tx_cnt + 16'd1;
                    end
                end
            endcase
        end
    end

    // ---------------- RX ----------------
    assign rx_s         = rx_sync[1];
    assign rx_end       = (rx_cnt >= div - 16'd1);
    assign rx_mid       = (rx_cnt >= {1'b0, div[15:1]} - 16'd1);
    assign rx_stop_done = (rx_state == ST_STOP) && rx_end;

    always_ff @(posedge clk) begin
        if (!rst) begin
            rx_sync  <= 2'b11;
            rx_prev  <= 1'b1;
            rx_state <= ST_IDLE;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_sh    <= '0;
        end else begin
            rx_sync <= {rx_sync[0], uart_rx_i};
            rx_prev <= rx_s;
            case (rx_state)
                ST_IDLE: begin
                    rx_cnt <= '0;
                    if (rx_prev && !rx_s) rx_state <= ST_START;
                end
                ST_START: begin
                    if (rx_mid) begin
                        rx_cnt   <= '0;
                        rx_bit   <= '0;
                        rx_state <= rx_s ? ST_IDLE : ST_DATA;
                    end else begin
                        rx_cnt <= rx_cnt + 16'd1;
                    end
                end
                ST_DATA: begin
                    if (rx_end) begin
                        rx_cnt <= '0;
                        rx_sh  <= {rx_s, rx_sh[7:1]};
                        if (rx_bit == 3'd7) rx_state <= ST_STOP;
                        else                rx_bit   <= rx_bit + 3'd1;
                    end else begin
                        rx_cnt <= rx_cnt + 16'd1;
                    end
                end
                default: begin
                    if (rx_end) begin
                        rx_cnt   <= '0;
                        rx_state <= ST_IDLE;
                    end else begin
                        rx_cnt <= rx_cnt + 16'd1;
                    end
                end
            endcase
        end
    end

    // Status, divisor and enables; event sets are written last so they win over W1C.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rx_valid  <= 1'b0;
            rx_byte   <= '0;
            rxovr     <= 1'b0;
            frame_err <= 1'b0;
            txovf     <= 1'b0;
            div       <= DIV_RST;
            ien       <= '0;
        end else begin
            if (stat_wr) begin
                if (wbs_wdata_i[STAT_RXOVR])     rxovr     <= 1'b0;
                if (wbs_wdata_i[STAT_FRAME_ERR]) frame_err <= 1'b0;
                if (wbs_wdata_i[STAT_TXOVF])     txovf     <= 1'b0;
            end
            if (tx_push_req && fifo_full) txovf <= 1'b1;
            if (rd_rx) rx_valid <= 1'b0;
            if (rx_stop_done) begin
                if (!rx_s) begin
                    frame_err <= 1'b1;
                end else if (!rx_valid || rd_rx) begin
                    rx_byte  <= rx_sh;
                    rx_valid <= 1'b1;
                end else begin
                    rxovr <= 1'b1;
                end
            end
            if (div_wr) div <= clamp_div(new_div);
            if (ien_wr) ien <= wbs_wdata_i[1:0];
        end
    end

    assign wbs_ack_o   = ack_q;
    assign wbs_rdata_o = rdata_q;
    assign uart_tx_o   = tx_line;
    assign irq_o       = irq_q;

endmodule

// File: tb/tb_wb_uart.sv
// Directed self-checking bench for wb_uart: bus, TX framing/overflow, RX/errors/irq, reset and glitch.
module tb_wb_uart;

    localparam logic [31:0] A_TXDATA = 32'h300;
    localparam logic [31:0] A_RXDATA = 32'h304;
    localparam logic [31:0] A_STAT   = 32'h308;
    localparam logic [31:0] A_DIV    = 32'h30C;
    localparam logic [31:0] A_IEN    = 32'h310;
    localparam logic [31:0] A_UNMAP  = 32'h31C;
    localparam int          DIVB     = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
    logic [31:0] addr = '0, wdata = '0;
    logic [3:0]  sel = '0;
    logic [31:0] rdata;
    logic        ack;
    logic        rx = 1'b1;
    logic        tx;
    logic        irq;

    int checks = 0;
    int errors = 0;
    int cyc_n  = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc_n <= cyc_n + 1;

    wb_uart dut (
        .clk         (clk),
        .rst         (rst),
        .wbs_cyc_i   (cyc),
        .wbs_stb_i   (stb),
        .wbs_we_i    (we),
        .wbs_addr_i  (addr),
        .wbs_wdata_i (wdata),
        .wbs_sel_i   (sel),
        .wbs_rdata_o (rdata),
        .wbs_ack_o   (ack),
        .uart_rx_i   (rx),
        .uart_tx_o   (tx),
        .irq_o       (irq)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // All bus/stimulus tasks start and end just after a rising edge.
    task automatic wb_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        int got = 0;
        cyc = 1'b1; stb = 1'b1; we = 1'b1; addr = a; wdata = d; sel = s;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (ack === 1'b1) begin got = 1; break; end
        end
        check("wr_ack", got, 1);
        @(posedge clk); #1;
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    task automatic wb_read(input logic [31:0] a, output logic [31:0] d, output int lat);
        lat = -1;
        d   = 'x;
        cyc = 1'b1; stb = 1'b1; we = 1'b0; addr = a; sel = 4'hF;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (ack === 1'b1) begin lat = i; d = rdata; break; end
        end
        @(posedge clk); #1;
        cyc = 1'b0; stb = 1'b0;
    endtask

    task automatic rd_check(input string tag, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] d;
        int          lat;
        wb_read(a, d, lat);
        check(tag, d, exp);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_irq(input string tag, input logic exp);
        @(negedge clk);
        check(tag, irq, exp);
        @(posedge clk); #1;
    endtask

    task automatic rx_send(input logic [7:0] b, input logic stop);
        logic [9:0] bits;
        bits = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx = bits[i];
            repeat (DIVB) @(posedge clk);
            #1;
        end
        rx = 1'b1;
    endtask

    // Waits for a start bit, then samples mid-bit; width is the initial low run in cycles.
    task automatic tx_capture(input int lim, output logic [7:0] b, output logic stop,
                              output int t0, output int width);
        logic run;
        t0 = -1; b = 'x; stop = 1'bx; width = 0;
        for (int i = 0; i < lim; i++) begin
            @(negedge clk);
            if (tx === 1'b0) begin t0 = cyc_n; break; end
        end
        if (t0 >= 0) begin
            width = 1;
            run   = 1'b1;
            for (int k = 1; k <= 38; k++) begin
                @(negedge clk);
                if (run && tx === 1'b0) width++;
                else                    run = 1'b0;
                if (k >= 6 && k <= 34 && ((k - 2) % DIVB) == 0) b[(k - 6) / DIVB] = tx;
                if (k == 38) stop = tx;
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        int          lat;
        logic [7:0]  b;
        logic        st;
        int          t0, w, prev;

        // ---- 1: reset state and register defaults ----
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_tx", tx, 1'b1);
        check("rst_ack", ack, 1'b0);
        check("rst_rdata", rdata, 32'h0);
        check("rst_irq", irq, 1'b0);
        @(posedge clk); #1;
        rst = 1'b1;
        idle(2);

        wb_read(A_STAT, d, lat);
        check("ack_latency", lat, 1);
        check("stat_reset", d, 32'h04);
        @(negedge clk);
        check("ack_one_cycle", ack, 1'b0);
        @(posedge clk); #1;
        rd_check("div_reset", A_DIV, 32'd434);
        rd_check("ien_reset", A_IEN, 32'h0);
        rd_check("txdata_read", A_TXDATA, 32'h0);
        rd_check("rxdata_reset", A_RXDATA, 32'h0);
        wb_write(A_UNMAP, 32'hFFFF_FFFF, 4'hF);
        rd_check("unmapped_read", A_UNMAP, 32'h0);

        wb_write(A_DIV, 32'd1, 4'h3);
        rd_check("div_clamp", A_DIV, 32'd2);
        wb_write(A_DIV, 32'h0000_1234, 4'h2);
        rd_check("div_lane", A_DIV, 32'h1202);
        wb_write(A_DIV, DIVB, 4'h3);
        rd_check("div_set", A_DIV, DIVB);

        // ---- 2: single TX frame 0xA5 ----
        fork
            wb_write(A_TXDATA, 32'hA5, 4'h1);
            tx_capture(100, b, st, t0, w);
        join
        check("t2_byte", b, 8'hA5);
        check("t2_stop", st, 1'b1);
        check("t2_start_width", w, DIVB);
        @(negedge clk);
        @(negedge clk);
        check("t2_idle_after_40", tx, 1'b1);
        @(posedge clk); #1;
        rd_check("t2_stat_idle", A_STAT, 32'h04);

        // ---- 3: burst; one byte moves straight to the shifter, so ten writes overflow ----
        fork
            begin
                for (int i = 0; i < 10; i++) wb_write(A_TXDATA, 32'h10 + i, 4'h1);
            end
            begin
                prev = 0;
                for (int f = 0; f < 9; f++) begin
                    tx_capture(120, b, st, t0, w);
                    check("t3_byte", b, 8'h10 + f[7:0]);
                    check("t3_stop", st, 1'b1);
                    if (f > 0) check("t3_no_gap", t0 - prev, 40);
                    prev = t0;
                end
                tx_capture(60, b, st, t0, w);
                check("t3_no_extra_frame", t0, -1);
            end
        join
        @(posedge clk); #1;
        rd_check("t3_txovf", A_STAT, 32'h44);
        wb_write(A_STAT, 32'h40, 4'h1);
        rd_check("t3_txovf_w1c", A_STAT, 32'h04);

        // ---- 4: RX frame, read-clear, interrupts ----
        rx_send(8'h3C, 1'b1);
        idle(8);
        rd_check("t4_stat_valid", A_STAT, 32'h05);
        rd_check("t4_rxdata", A_RXDATA, 32'h8000_003C);
        rd_check("t4_stat_cleared", A_STAT, 32'h04);
        wb_write(A_IEN, 32'h1, 4'h1);
        check_irq("t4_irq_none", 1'b0);
        rx_send(8'h5A, 1'b1);
        idle(8);
        check_irq("t4_irq_rx", 1'b1);
        rd_check("t4_rxdata2", A_RXDATA, 32'h8000_005A);
        check_irq("t4_irq_drop", 1'b0);
        wb_write(A_IEN, 32'h2, 4'h1);
        check_irq("t4_irq_txempty", 1'b1);
        wb_write(A_IEN, 32'h0, 4'h1);
        check_irq("t4_irq_off", 1'b0);

        // ---- 5: overrun and framing error ----
        rx_send(8'h11, 1'b1);
        idle(4);
        rx_send(8'h22, 1'b1);
        idle(8);
        rd_check("t5_stat_ovr", A_STAT, 32'h15);
        rd_check("t5_rxdata_first", A_RXDATA, 32'h8000_0011);
        wb_write(A_STAT, 32'h10, 4'h1);
        rd_check("t5_ovr_w1c", A_STAT, 32'h04);
        rx_send(8'h33, 1'b0);
        idle(8);
        rd_check("t5_stat_ferr", A_STAT, 32'h24);
        rd_check("t5_rxdata_kept", A_RXDATA, 32'h0000_0011);
        wb_write(A_STAT, 32'h20, 4'h1);
        rd_check("t5_ferr_w1c", A_STAT, 32'h04);

        // ---- 6: reset mid-frame, then RX glitch ----
        wb_write(A_TXDATA, 32'h00, 4'h1);
        rx = 1'b0;
        idle(10);
        @(negedge clk);
        check("t6_tx_midframe", tx, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        rx  = 1'b1;
        @(negedge clk);
        check("t6_tx_after_rst", tx, 1'b1);
        @(posedge clk); #1;
        rd_check("t6_stat_after_rst", A_STAT, 32'h04);
        rd_check("t6_div_after_rst", A_DIV, 32'd434);
        wb_write(A_DIV, DIVB, 4'h3);
        rx = 1'b0;
        @(posedge clk); #1;
        rx = 1'b1;
        idle(60);
        rd_check("t6_glitch_stat", A_STAT, 32'h04);
        rd_check("t6_glitch_rxdata", A_RXDATA, 32'h0);
        check("t6_tx_idle", tx, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
